// File: rtl/tr_link_seq_pkg.sv
// Shared types and helpers for the transceiver link bring-up sequencer.
//   tr_pll_state_t  : fPLL sequencer states
//   tr_lane_state_t : per-lane qualification states
//   sat_inc8        : 8-bit saturating increment
package tr_link_seq_pkg;

  typedef enum logic [1:0] {P_PD, P_LOCK, P_RUN} tr_pll_state_t;
  typedef enum logic [1:0] {L_RST, L_RDY, L_SYNC, L_UP} tr_lane_state_t;

  localparam logic [7:0] RetryMax = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == RetryMax) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tr_link_seq_if.sv
// Bundle of fPLL and lane status/control signals around the link sequencer.
//   master : sequencer side (drives fpll_pd, lane_rst, link_up, fifo_rst, pll_retries)
//   slave  : fPLL/lane side (drives lock/cal status, lane ready/sync, pd requests)
interface tr_link_seq_if #(
  parameter int unsigned NUM_TR = 3
);
  logic [NUM_TR-1:0] lane_pd_req;
  logic              fpll_locked;
  logic              fpll_cal_busy;
  logic              fpll_pd;
  logic [NUM_TR-1:0] lane_tx_rdy;
  logic [NUM_TR-1:0] lane_rx_rdy;
  logic [NUM_TR-1:0] lane_sync;
  logic [NUM_TR-1:0] lane_rst;
  logic [NUM_TR-1:0] link_up;
  logic [NUM_TR-1:0] fifo_rst;
  logic [7:0]        pll_retries;

  modport master (
    input  lane_pd_req, fpll_locked, fpll_cal_busy, lane_tx_rdy, lane_rx_rdy, lane_sync,
    output fpll_pd, lane_rst, link_up, fifo_rst, pll_retries
  );

  modport slave (
    output lane_pd_req, fpll_locked, fpll_cal_busy, lane_tx_rdy, lane_rx_rdy, lane_sync,
    input  fpll_pd, lane_rst, link_up, fifo_rst, pll_retries
  );
endinterface

// File: rtl/tr_lane_fsm.sv
// Per-lane qualification FSM: holds the lane in reset until the fPLL is usable, then waits
// for tx/rx ready and a run of SYNC_HOLD consecutive sync cycles before declaring link_up.
//   clk, rst  : clock, synchronous active-high reset
//   pll_ok    : fPLL will be in its run state after this edge
//   tx_rdy, rx_rdy, sync : lane status
//   lane_rst, link_up, fifo_rst : registered lane controls
module tr_lane_fsm
  import tr_link_seq_pkg::*;
#(
  parameter int unsigned RDY_TIMEOUT  = 65536,
  parameter int unsigned SYNC_TIMEOUT = 262144,
  parameter int unsigned SYNC_HOLD    = 16,
  parameter int unsigned LANE_RST_CYC = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_ok,
  input  logic tx_rdy,
  input  logic rx_rdy,
  input  logic sync,
  output logic lane_rst,
  output logic link_up,
  output logic fifo_rst
);

  localparam int unsigned TmrMax0 = (RDY_TIMEOUT > SYNC_TIMEOUT) ? RDY_TIMEOUT : SYNC_TIMEOUT;
  localparam int unsigned TmrMax  = (TmrMax0 > LANE_RST_CYC) ? TmrMax0 : LANE_RST_CYC;
  localparam int unsigned TmrW    = $clog2(TmrMax + 1);
  localparam int unsigned HoldW   = $clog2(SYNC_HOLD + 1);

  localparam logic [TmrW-1:0]  RstLast  = TmrW'(LANE_RST_CYC - 1);
  localparam logic [TmrW-1:0]  RdyLast  = TmrW'(RDY_TIMEOUT - 1);
  localparam logic [TmrW-1:0]  SyncLast = TmrW'(SYNC_TIMEOUT - 1);
  localparam logic [TmrW-1:0]  TmrSat   = TmrW'(TmrMax);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(SYNC_HOLD - 1);
  localparam logic [HoldW-1:0] HoldSat  = HoldW'(SYNC_HOLD);

  tr_lane_state_t   state_q, state_d;
  logic [TmrW-1:0]  tmr_q, tmr_d, tmr_inc;
  logic [HoldW-1:0] hold_q, hold_d, hold_inc;
  logic             fifo_rst_q;
  logic             rdy;

  assign rdy      = tx_rdy & rx_rdy;
  assign tmr_inc  = (tmr_q == TmrSat) ? tmr_q : tmr_q + 1'b1;
  assign hold_inc = (hold_q == HoldSat) ? hold_q : hold_q + 1'b1;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_inc;
    hold_d  = hold_q;
    unique case (state_q)
      L_RST: begin
        // Freeze once the minimum reset time is served; exit waits only on the PLL.
        tmr_d = (tmr_q >= RstLast) ? tmr_q : tmr_q + 1'b1;
        if (pll_ok && (tmr_q >= RstLast)) state_d = L_RDY;
      end
      L_RDY: begin
        if (!pll_ok)                state_d = L_RST;
        else if (tmr_q == RdyLast)  state_d = L_RST;
        else if (rdy)               state_d = L_SYNC;
      end
      L_SYNC: begin
        hold_d = sync ? hold_inc : '0;
        if (!pll_ok)                          state_d = L_RST;
        else if (!rdy)                        state_d = L_RST;
        else if (tmr_q == SyncLast)           state_d = L_RST;
        else if (sync && hold_q == HoldLast)  state_d = L_UP;
      end
      L_UP: begin
        if (!pll_ok)     state_d = L_RST;
        else if (!rdy)   state_d = L_RST;
        else if (!sync)  state_d = L_SYNC;
      end
      default: state_d = L_RST;
    endcase
    if (state_d != state_q) begin
      tmr_d  = '0;
      hold_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= L_RST;
      tmr_q      <= '0;
      hold_q     <= '0;
      fifo_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      hold_q     <= hold_d;
      fifo_rst_q <= (state_q != L_UP);
    end
  end

  assign lane_rst = (state_q == L_RST);
  assign link_up  = (state_q == L_UP);
  assign fifo_rst = fifo_rst_q;

endmodule

// File: rtl/tr_link_seq.sv
// Bring-up sequencer for NUM_TR lanes sharing one fPLL: pulses fPLL powerdown, waits for
// lock with calibration idle (retrying on timeout), then releases and qualifies each lane.
//   clk, rst : clock, synchronous active-high reset
//   bus      : tr_link_seq_if master (fPLL status/powerdown, lane status/controls, retries)
module tr_link_seq
  import tr_link_seq_pkg::*;
#(
  parameter int unsigned NUM_TR       = 3,
  parameter int unsigned PD_CYCLES    = 64,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned RDY_TIMEOUT  = 65536,
  parameter int unsigned SYNC_TIMEOUT = 262144,
  parameter int unsigned SYNC_HOLD    = 16,
  parameter int unsigned LANE_RST_CYC = 32
) (
  input logic           clk,
  input logic           rst,
  tr_link_seq_if.master bus
);

  localparam int unsigned PcMax = (PD_CYCLES > LOCK_TIMEOUT) ? PD_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned PcW   = $clog2(PcMax + 1);

  localparam logic [PcW-1:0] PdLast   = PcW'(PD_CYCLES - 1);
  localparam logic [PcW-1:0] LockLast = PcW'(LOCK_TIMEOUT - 1);
  localparam logic [PcW-1:0] PcSat    = PcW'(PcMax);

  tr_pll_state_t   pll_q, pll_d;
  logic [PcW-1:0]  pcnt_q, pcnt_d;
  logic [7:0]      retries_q, retries_d;
  logic            pll_ok;

  logic [NUM_TR-1:0] lane_rst_v, link_up_v, fifo_rst_v;

  always_comb begin
    pll_d     = pll_q;
    pcnt_d    = (pcnt_q == PcSat) ? pcnt_q : pcnt_q + 1'b1;
    retries_d = retries_q;
    unique case (pll_q)
      P_PD: begin
        if (pcnt_q == PdLast) pll_d = P_LOCK;
      end
      P_LOCK: begin
        if (pcnt_q == LockLast) begin
          pll_d     = P_PD;
          retries_d = sat_inc8(retries_q);
        end else if (bus.fpll_locked && !bus.fpll_cal_busy) begin
          pll_d = P_RUN;
        end
      end
      P_RUN: begin
        if (!bus.fpll_locked || bus.fpll_cal_busy || (|bus.lane_pd_req)) pll_d = P_PD;
      end
      default: pll_d = P_PD;
    endcase
    if (pll_d != pll_q) pcnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pll_q     <= P_PD;
      pcnt_q    <= '0;
      retries_q <= '0;
    end else begin
      pll_q     <= pll_d;
      pcnt_q    <= pcnt_d;
      retries_q <= retries_d;
    end
  end

  // Lanes look at the PLL's next state so a PLL drop resets them on the same edge
  // that raises fpll_pd.
  assign pll_ok = (pll_d == P_RUN);

  for (genvar g = 0; g < NUM_TR; g++) begin : g_lane
    tr_lane_fsm #(
      .RDY_TIMEOUT  (RDY_TIMEOUT),
      .SYNC_TIMEOUT (SYNC_TIMEOUT),
      .SYNC_HOLD    (SYNC_HOLD),
      .LANE_RST_CYC (LANE_RST_CYC)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .pll_ok   (pll_ok),
      .tx_rdy   (bus.lane_tx_rdy[g]),
      .rx_rdy   (bus.lane_rx_rdy[g]),
      .sync     (bus.lane_sync[g]),
      .lane_rst (lane_rst_v[g]),
      .link_up  (link_up_v[g]),
      .fifo_rst (fifo_rst_v[g])
    );
  end

  assign bus.fpll_pd     = (pll_q == P_PD);
  assign bus.pll_retries = retries_q;
  assign bus.lane_rst    = lane_rst_v;
  assign bus.link_up     = link_up_v;
  assign bus.fifo_rst    = fifo_rst_v;

endmodule
